gyruss_sndcmd_tx: RTL

//  Main-CPU-side transmitter of the sound command link. Queues command bytes written by the

---
 rtl/gyruss_sndcmd_tx_pkg.sv | 25 ++
 rtl/gyruss_sndcmd_tx_fifo.sv | 60 ++++++
 rtl/gyruss_sndcmd_tx.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/gyruss_sndcmd_tx_pkg.sv
// Shared definitions for the sound command link: FSM encodings, default timing
// and the counter-load helper. The sound-side bench models reuse the defaults.
package gyruss_sndcmd_tx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    PULSE    = 2'd2,
    WAIT_ACK = 2'd3
  } snd_state_t;

  localparam int DEF_DEPTH_LOG2  = 2;
  localparam int DEF_SETUP_CYC   = 4;
  localparam int DEF_PULSE_CYC   = 8;
  localparam int DEF_TIMEOUT_CYC = 49152;

  // Wide enough for the 1 ms ack timeout at 49.152 MHz.
  localparam int CNT_W = 16;

  // Down-counters run from cycles-1 to 0, so a phase lasts exactly 'cycles' edges.
  function automatic logic [CNT_W-1:0] cyc_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/gyruss_sndcmd_tx_fifo.sv
// Small synchronous FIFO holding pending sound command bytes. The head byte is
// visible on dout whenever the FIFO is not empty (first-word fall-through).
module sndcmd_fifo #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign empty   = (count == '0);
  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array; written on accepted pushes only, contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (DEPTH_LOG2+1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gyruss_sndcmd_tx.sv
// Main-CPU side of the sound command link. Queues command bytes and hands each
// to the sound board as SNDNO followed by an SNDRQ strobe, then waits for the
// sound CPU's interrupt-accept (or a timeout) before starting the next one.
module gyruss_sndcmd_tx
  import gyruss_sndcmd_tx_pkg::*;
#(
  parameter int DEPTH_LOG2  = DEF_DEPTH_LOG2,
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int PULSE_CYC   = DEF_PULSE_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic       MCLK,
  input  logic       sndreqrst,
  input  logic       cmd_wr,
  input  logic [7:0] cmd_data,
  input  logic       ack,
  input  logic       clr_flags,
  output logic       SNDRQ,
  output logic [7:0] SNDNO,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow,
  output logic       timeout
);

  snd_state_t            state;
  logic [CNT_W-1:0]      cnt;
  logic                  ack_meta;
  logic                  ack_sync;
  logic                  ack_prev;
  logic                  ack_rise;
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic                  fifo_is_full;
  logic [7:0]            fifo_dout;
  logic [DEPTH_LOG2:0]   fifo_count;
  logic                  overflow_set;
  logic                  timeout_set;

  sndcmd_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (MCLK),
    .rst   (sndreqrst),
    .push  (cmd_wr),
    .pop   (fifo_pop),
    .din   (cmd_data),
    .dout  (fifo_dout),
    .full  (fifo_is_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Count never exceeds the depth, so its MSB alone marks the full condition.
  assign fifo_full    = fifo_count[DEPTH_LOG2];
  assign busy         = (state != IDLE) | ~fifo_empty;
  assign fifo_pop     = (state == IDLE) & ~fifo_empty;
  assign ack_rise     = ack_sync & ~ack_prev;
  assign overflow_set = cmd_wr & fifo_is_full & ~fifo_pop;
  // An ack arriving on the last wait cycle takes priority over the timeout.
  assign timeout_set  = (state == WAIT_ACK) & ~ack_rise & (cnt == '0);

  // Bring the asynchronous accept pulse into MCLK and keep one delayed copy for edge detection.
  always_ff @(posedge MCLK or posedge sndreqrst) begin
    if (sndreqrst) begin
      ack_meta <= 1'b0;
      ack_sync <= 1'b0;
      ack_prev <= 1'b0;
    end else begin
      ack_meta <= ack;
      ack_sync <= ack_meta;
      ack_prev <= ack_sync;
    end
  end

  // Send sequencer: load byte, hold setup, strobe, then wait for accept or timeout.
  always_ff @(posedge MCLK or posedge sndreqrst) begin
    if (sndreqrst) begin
      state <= IDLE;
      cnt   <= '0;
      SNDRQ <= 1'b0;
      SNDNO <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            SNDNO <= fifo_dout;
            cnt   <= cyc_load(SETUP_CYC);
            state <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            SNDRQ <= 1'b1;
            cnt   <= cyc_load(PULSE_CYC);
            state <= PULSE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            SNDRQ <= 1'b0;
            cnt   <= cyc_load(TIMEOUT_CYC);
            state <= WAIT_ACK;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WAIT_ACK: begin
          if (ack_rise || cnt == '0) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          SNDRQ <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Sticky error flags; a set event in the same cycle as a clear keeps the flag set.
  always_ff @(posedge MCLK or posedge sndreqrst) begin
    if (sndreqrst) begin
      overflow <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (overflow_set) begin
        overflow <= 1'b1;
      end else if (clr_flags) begin
        overflow <= 1'b0;
      end
      if (timeout_set) begin
        timeout <= 1'b1;
      end else if (clr_flags) begin
        timeout <= 1'b0;
      end
    end
  end

endmodule
